// File: rtl/gv_pkg.sv
// Shared types, sizes and helpers for the Guitar Villains note sequencer.
package gv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int ROW_W    = 7;
  localparam int SONG_LEN = 32;
  localparam int MAX_MISS = 8;
  localparam int SCORE_W  = 8;
  localparam int MISS_W   = 4;
  localparam int IDX_W    = $clog2(SONG_LEN);
  // One extra bit so beat_idx can rest at SONG_LEN once the song is exhausted.
  localparam int BEAT_W   = $clog2(SONG_LEN + 1);

  // Per-cycle increments are at most 2 (one event per lane).
  function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] val,
                                                       input logic [1:0]         inc);
    logic [SCORE_W:0] sum;
    sum = {1'b0, val} + {{(SCORE_W-1){1'b0}}, inc};
    if (sum[SCORE_W]) sat_inc_score = '1;
    else              sat_inc_score = sum[SCORE_W-1:0];
  endfunction

  function automatic logic [MISS_W-1:0] sat_inc_miss(input logic [MISS_W-1:0] val,
                                                     input logic [1:0]        inc);
    logic [MISS_W:0] sum;
    sum = {1'b0, val} + {{(MISS_W-1){1'b0}}, inc};
    if (sum[MISS_W]) sat_inc_miss = '1;
    else             sat_inc_miss = sum[MISS_W-1:0];
  endfunction

endpackage

// File: rtl/gv_note_sequencer_if.sv
// Bus between the song source / buttons / display logic and the sequencer.
//   start, buttons, song_top, song_bot : into the sequencer
//   top_row, bottom_row, score, misses, hit_flash, miss_flash,
//   busy, done, failed                 : out of the sequencer
// master = environment side, slave = sequencer side.
interface gv_note_sequencer_if;
  import gv_pkg::*;

  logic                start;
  logic [1:0]          buttons;
  logic [SONG_LEN-1:0] song_top;
  logic [SONG_LEN-1:0] song_bot;
  logic [ROW_W-1:0]    top_row;
  logic [ROW_W-1:0]    bottom_row;
  logic [SCORE_W-1:0]  score;
  logic [MISS_W-1:0]   misses;
  logic                hit_flash;
  logic                miss_flash;
  logic                busy;
  logic                done;
  logic                failed;

  modport master (
    output start, buttons, song_top, song_bot,
    input  top_row, bottom_row, score, misses, hit_flash, miss_flash, busy, done, failed
  );

  modport slave (
    input  start, buttons, song_top, song_bot,
    output top_row, bottom_row, score, misses, hit_flash, miss_flash, busy, done, failed
  );
endinterface

// File: rtl/gv_lane.sv
// One note lane: LED row shift register, button rising-edge detector and
// hit/miss judgement against the strike column (bit 0).
//   clk, reset  : clock, synchronous active-high reset
//   clear_i     : game start, empties the row and the button history
//   play_i      : game running; presses are ignored otherwise
//   tick_i      : beat strobe, scrolls the row one step toward bit 0
//   entry_i     : note entering at bit ROW_W-1 on this tick
//   button_i    : synchronised lane button level
//   row_o       : LED row
//   pending_o   : row holds any note after this cycle's press was judged
//   hit_o       : press landed on a note
//   miss_o      : bad press, or a note left the strike column unhit
module gv_lane
  import gv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             play_i,
  input  logic             tick_i,
  input  logic             entry_i,
  input  logic             button_i,
  output logic [ROW_W-1:0] row_o,
  output logic             pending_o,
  output logic             hit_o,
  output logic             miss_o
);

  logic [ROW_W-1:0] row_q, row_d, row_judged;
  logic             btn_prev_q;
  logic             press;

  assign press = play_i & button_i & ~btn_prev_q;

  // Press is judged against the pre-tick row; only what survives the
  // judgement can be a tick miss, so a lane yields at most one event.
  always_comb begin
    row_judged = row_q;
    hit_o      = press & row_q[0];
    miss_o     = press & ~row_q[0];
    if (hit_o) row_judged[0] = 1'b0;
    if (play_i && tick_i && row_judged[0]) miss_o = 1'b1;
    row_d = row_judged;
    if (clear_i)               row_d = '0;
    else if (play_i && tick_i) row_d = {entry_i, row_judged[ROW_W-1:1]};
  end

  assign pending_o = |row_judged;
  assign row_o     = row_q;

  // History cleared on start so a button held through start counts as a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q      <= '0;
      btn_prev_q <= 1'b0;
    end else begin
      row_q      <= row_d;
      btn_prev_q <= clear_i ? 1'b0 : button_i;
    end
  end

endmodule

// File: rtl/gv_note_sequencer.sv
// Guitar Villains game controller: latches a two-lane song, generates the
// beat tick, scrolls notes toward the strike column, judges presses and
// keeps score / misses.
//   clk, reset : clock, synchronous active-high reset
//   bus        : gv_note_sequencer_if.slave (start, buttons, songs in;
//                rows, score, misses, flashes, busy, done, failed out)
//
// state   | meaning
// IDLE    | after reset, waiting for start
// PLAY    | beat ticks run, notes scroll, presses judged
// DONE    | song finished or too many misses; outputs hold until start
module gv_note_sequencer
  import gv_pkg::*;
#(
  parameter int TICK_DIV = 3_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  gv_note_sequencer_if.slave   bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    tick_cnt_q;
  logic [BEAT_W-1:0]   beat_idx_q;
  logic [SONG_LEN-1:0] song_top_q, song_bot_q;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [MISS_W-1:0]   misses_q, misses_d;
  logic                hit_flash_q, hit_flash_d;
  logic                miss_flash_q, miss_flash_d;
  logic                failed_q, failed_d;

  logic             play, clear, tick, song_left;
  logic             entry_top, entry_bot;
  logic             hit_top, hit_bot, miss_top, miss_bot;
  logic             pend_top, pend_bot;
  logic [1:0]       hit_cnt, miss_cnt;
  logic [ROW_W-1:0] row_top, row_bot;

  assign play      = (state_q == ST_PLAY);
  assign clear     = bus.start & ~play;
  assign tick      = play && (tick_cnt_q == CNT_W'(TICK_DIV - 1));
  assign song_left = (beat_idx_q < BEAT_W'(SONG_LEN));
  assign entry_top = song_left ? song_top_q[beat_idx_q[IDX_W-1:0]] : 1'b0;
  assign entry_bot = song_left ? song_bot_q[beat_idx_q[IDX_W-1:0]] : 1'b0;

  gv_lane u_lane_top (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (clear),
    .play_i    (play),
    .tick_i    (tick),
    .entry_i   (entry_top),
    .button_i  (bus.buttons[1]),
    .row_o     (row_top),
    .pending_o (pend_top),
    .hit_o     (hit_top),
    .miss_o    (miss_top)
  );

  gv_lane u_lane_bot (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (clear),
    .play_i    (play),
    .tick_i    (tick),
    .entry_i   (entry_bot),
    .button_i  (bus.buttons[0]),
    .row_o     (row_bot),
    .pending_o (pend_bot),
    .hit_o     (hit_bot),
    .miss_o    (miss_bot)
  );

  assign hit_cnt  = {1'b0, hit_top}  + {1'b0, hit_bot};
  assign miss_cnt = {1'b0, miss_top} + {1'b0, miss_bot};

  always_comb begin
    score_d      = score_q;
    misses_d     = misses_q;
    hit_flash_d  = hit_flash_q;
    miss_flash_d = miss_flash_q;
    if (clear) begin
      score_d      = '0;
      misses_d     = '0;
      hit_flash_d  = 1'b0;
      miss_flash_d = 1'b0;
    end else begin
      score_d  = sat_inc_score(score_q, hit_cnt);
      misses_d = sat_inc_miss(misses_q, miss_cnt);
      // A tick wipes old flashes; only this cycle's events survive it.
      if (tick) begin
        hit_flash_d  = |hit_cnt;
        miss_flash_d = |miss_cnt;
      end else begin
        hit_flash_d  = hit_flash_q  | (|hit_cnt);
        miss_flash_d = miss_flash_q | (|miss_cnt);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    failed_d = failed_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_PLAY;
          failed_d = 1'b0;
        end
      end
      ST_PLAY: begin
        if (misses_d >= MISS_W'(MAX_MISS)) begin
          state_d  = ST_DONE;
          failed_d = 1'b1;
        end else if (tick && !song_left && !pend_top && !pend_bot) begin
          state_d  = ST_DONE;
          failed_d = 1'b0;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          state_d  = ST_PLAY;
          failed_d = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        failed_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tick_cnt_q   <= '0;
      beat_idx_q   <= '0;
      song_top_q   <= '0;
      song_bot_q   <= '0;
      score_q      <= '0;
      misses_q     <= '0;
      hit_flash_q  <= 1'b0;
      miss_flash_q <= 1'b0;
      failed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      misses_q     <= misses_d;
      hit_flash_q  <= hit_flash_d;
      miss_flash_q <= miss_flash_d;
      failed_q     <= failed_d;
      if (clear) begin
        tick_cnt_q <= '0;
        beat_idx_q <= '0;
        song_top_q <= bus.song_top;
        song_bot_q <= bus.song_bot;
      end else if (play) begin
        tick_cnt_q <= tick ? '0 : tick_cnt_q + CNT_W'(1);
        if (tick && song_left) beat_idx_q <= beat_idx_q + BEAT_W'(1);
      end
    end
  end

  assign bus.top_row    = row_top;
  assign bus.bottom_row = row_bot;
  assign bus.score      = score_q;
  assign bus.misses     = misses_q;
  assign bus.hit_flash  = hit_flash_q;
  assign bus.miss_flash = miss_flash_q;
  assign bus.busy       = play;
  assign bus.done       = (state_q == ST_DONE);
  assign bus.failed     = failed_q;

endmodule

// File: tb/tb_gv_note_sequencer.sv
// Directed bench for gv_note_sequencer with TICK_DIV=4: ticks land on the
// 4th, 8th, ... rising edge after the start edge.
module tb_gv_note_sequencer;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  gv_note_sequencer_if bus ();

  gv_note_sequencer #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  // Leaves the bench just after the start edge (edge 0).
  task automatic start_game(input logic [31:0] top, input logic [31:0] bot);
    bus.song_top = top;
    bus.song_bot = bot;
    bus.start    = 1'b1;
    step(1);
    bus.start    = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.top_row, bus.bottom_row, bus.score, bus.misses, bus.hit_flash,
                bus.miss_flash, bus.busy, bus.done, bus.failed});
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.buttons  = 2'b00;
    bus.song_top = '0;
    bus.song_bot = '0;

    do_reset();
    chk("reset_outs", all_outs(), 32'h0);

    // Single top note, never pressed.
    start_game(32'h1, 32'h0);
    chk("t1_busy", 32'(bus.busy), 32'h1);
    step(4);
    chk("t1_row_tick1", 32'(bus.top_row), 32'h40);
    step(24);
    chk("t1_row_tick7", 32'(bus.top_row), 32'h01);
    chk("t1_miss_pre", 32'(bus.misses), 32'h0);
    step(4);
    chk("t1_miss_tick8", 32'(bus.misses), 32'h1);
    chk("t1_mflash_tick8", 32'(bus.miss_flash), 32'h1);
    chk("t1_row_tick8", 32'(bus.top_row), 32'h0);
    step(99);
    chk("t1_not_done_tick32", 32'(bus.done), 32'h0);
    step(1);
    chk("t1_done_tick33", 32'(bus.done), 32'h1);
    chk("t1_failed", 32'(bus.failed), 32'h0);
    chk("t1_busy_done", 32'(bus.busy), 32'h0);

    // Same song, restarted from DONE, hit between tick 7 and tick 8.
    start_game(32'h1, 32'h0);
    chk("t2_cleared_misses", 32'(bus.misses), 32'h0);
    step(28);
    bus.buttons = 2'b10;
    step(1);
    bus.buttons = 2'b00;
    chk("t2_score", 32'(bus.score), 32'h1);
    chk("t2_hflash", 32'(bus.hit_flash), 32'h1);
    chk("t2_row", 32'(bus.top_row), 32'h0);
    step(103);
    chk("t2_done", 32'(bus.done), 32'h1);
    chk("t2_misses", 32'(bus.misses), 32'h0);
    chk("t2_score_end", 32'(bus.score), 32'h1);

    // Full song on both lanes, both pressed once per tick window.
    do_reset();
    start_game(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(28);
    for (int i = 0; i < 32; i++) begin
      bus.buttons = 2'b11;
      step(1);
      bus.buttons = 2'b00;
      chk("t3_score_step", 32'(bus.score), 32'(2 * (i + 1)));
      step(3);
    end
    chk("t3_done", 32'(bus.done), 32'h1);
    chk("t3_score", 32'(bus.score), 32'd64);
    chk("t3_misses", 32'(bus.misses), 32'h0);
    chk("t3_failed", 32'(bus.failed), 32'h0);

    // Empty song, eight bad presses on the bottom lane.
    do_reset();
    start_game(32'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      bus.buttons = 2'b01;
      step(1);
      bus.buttons = 2'b00;
      if (i == 6) begin
        chk("t4_misses7", 32'(bus.misses), 32'd7);
        chk("t4_not_done7", 32'(bus.done), 32'h0);
      end
      if (i < 7) step(1);
    end
    chk("t4_misses8", 32'(bus.misses), 32'd8);
    chk("t4_done", 32'(bus.done), 32'h1);
    chk("t4_failed", 32'(bus.failed), 32'h1);
    bus.buttons = 2'b01;
    step(10);
    bus.buttons = 2'b00;
    chk("t4_frozen_misses", 32'(bus.misses), 32'd8);
    chk("t4_frozen_rows", 32'({bus.top_row, bus.bottom_row}), 32'h0);
    chk("t4_still_done", 32'(bus.done), 32'h1);

    // Score 5, start mid-PLAY ignored, then reset mid-PLAY.
    do_reset();
    start_game(32'hFFFF_FFFF, 32'h0);
    step(28);
    for (int i = 0; i < 5; i++) begin
      bus.buttons = 2'b10;
      step(1);
      bus.buttons = 2'b00;
      step(3);
    end
    chk("t5_score5", 32'(bus.score), 32'd5);
    chk("t5_row_full", 32'(bus.top_row), 32'h7F);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    chk("t5_start_ign_score", 32'(bus.score), 32'd5);
    chk("t5_start_ign_row", 32'(bus.top_row), 32'h7F);
    chk("t5_start_ign_busy", 32'(bus.busy), 32'h1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t5_reset_outs", all_outs(), 32'h0);

    // Both lanes miss on the same tick.
    start_game(32'h1, 32'h1);
    step(28);
    chk("t6_misses_pre", 32'(bus.misses), 32'h0);
    step(4);
    chk("t6_double_miss", 32'(bus.misses), 32'd2);
    chk("t6_mflash", 32'(bus.miss_flash), 32'h1);

    // Hit on top and bad press on bottom in one cycle.
    do_reset();
    start_game(32'h1, 32'h0);
    step(28);
    bus.buttons = 2'b11;
    step(1);
    bus.buttons = 2'b00;
    chk("t7_score", 32'(bus.score), 32'h1);
    chk("t7_misses", 32'(bus.misses), 32'h1);
    chk("t7_flashes", 32'({bus.hit_flash, bus.miss_flash}), 32'h3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gv_note_sequencer.md
Name: gv_note_sequencer

Overview:
- Game controller for Guitar Villains. Latches a two-lane song, generates the beat tick, and scrolls notes across two 7-LED rows toward the strike column.
- Judges lane-button presses as hits or misses, and tracks score and misses.
- Sequences the game through idle, play and done. Sits between the song source/buttons and the LED/7-segment display logic.

Parameters:
- TICK_DIV, 3_000_000, clk cycles per beat tick (4 beats/s at 12 MHz); benches use 4.
- SONG_LEN, 32, beats per song; one bit per lane per beat.
- ROW_W, 7, LEDs per lane row; bit ROW_W-1 is entry, bit 0 is strike column.
- MAX_MISS, 8, miss count that ends the game as failed.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; starts a game from IDLE or DONE, ignored in PLAY
- buttons  in  2  synchronised lane buttons, level; [1]=top lane, [0]=bottom lane
- song_top  in  32  top-lane beat map, bit k = note on beat k; sampled on start
- song_bot  in  32  bottom-lane beat map; sampled on start
- top_row  out  7  top-lane LEDs
- bottom_row  out  7  bottom-lane LEDs
- score  out  8  hit count, saturating at 255
- misses  out  4  miss count, saturating at 15
- hit_flash  out  1  green indicator
- miss_flash  out  1  red indicator
- busy  out  1  high in PLAY
- done  out  1  high in DONE
- failed  out  1  high in DONE when the game ended by MAX_MISS

Behaviour:
- Reset (synchronous, any state, including mid-game):
  - state=IDLE; all outputs 0.
  - Tick counter, beat_idx and latched songs cleared.
- FSM states:
  - IDLE -> PLAY on start.
  - PLAY -> DONE on the end or fail condition.
  - DONE -> PLAY on start; outputs hold until then.
- On start:
  - Latch both songs; clear rows, score, misses, flashes, failed, beat_idx and tick counter.
  - Enter PLAY next cycle.
- Tick:
  - In PLAY, the counter runs 0..TICK_DIV-1; tick is a 1-cycle strobe at the terminal count.
  - First tick occurs TICK_DIV cycles after the start cycle. Counter frozen outside PLAY.
- Button edges:
  - Rising edge per lane, using the registered previous level. The previous level is cleared on start, so a button held through start yields an edge.
  - Edge with row[0]=1: hit. score+1, that lane's row[0] cleared, hit_flash set.
  - Edge with row[0]=0: bad press. misses+1, miss_flash set.
  - Edges are judged only in PLAY.
- Tick processing, in order within the same cycle:
  1. Judge any edge this cycle against the pre-tick rows.
  2. For each lane still holding row[0]=1, add a miss (lanes independent; two misses possible in one tick).
  3. Shift each row to {entry, row[ROW_W-1:1]}. entry = song[beat_idx] if beat_idx < SONG_LEN, else 0.
  4. beat_idx increments and saturates at SONG_LEN.
  5. Clear both flashes unless set by an edge in this same cycle.
- Simultaneous events:
  - Both lanes hit in one cycle: score+2.
  - A hit and a miss in the same cycle both apply.
  - Counters add per-cycle totals with saturation.
- End condition: on a tick with beat_idx==SONG_LEN and both post-judgement pre-shift rows all zero -> DONE, failed=0.
- Fail condition: misses >= MAX_MISS after any update -> DONE next cycle, failed=1. Rows freeze.
- Latency: row/score/flag updates are registered, visible the cycle after the event.

Decomposition:
- Package gv_pkg holds:
  - state enum {IDLE, PLAY, DONE}
  - ROW_W, SONG_LEN, score/miss widths
  - saturating-increment function
- Sub-module gv_lane, instantiated twice. It holds the row shift register, button edge detector and hit/miss judgement. Outputs: row, hit and miss strobes.
- Top level holds the FSM, tick counter, beat_idx, counters and flashes.

Test Plan:
- TICK_DIV=4, song_top=32'h1, song_bot=0, start at cycle 0, no presses:
  - top_row=7'b1000000 after tick 1 (cycle 4).
  - top_row[0]=1 after tick 7.
  - misses=1, miss_flash=1 after tick 8.
  - done=1, failed=0 after tick 33.
- Same song, top button rising edge between tick 7 and tick 8 -> score=1, hit_flash=1, top_row=0; misses stays 0 through DONE.
- Both songs 32'hFFFFFFFF, both buttons pulsed once every tick after tick 7 -> score increments by 2 per tick, misses=0, final score=64.
- Song all zero, bottom button pulsed 8 times in PLAY -> misses=8; done=1, failed=1 the cycle after the 8th update; rows frozen.
- reset asserted mid-PLAY with score=5 -> next cycle all outputs 0, IDLE. start during PLAY is ignored (beat_idx unchanged).
- Both lanes miss on the same tick (songs 32'h1 each) -> misses increments by 2 in one cycle. A hit and a miss on the same cycle updates both counters.
